// File: rtl/mdu.sv
// Multiply/divide unit with architectural HI/LO registers.
// Multiplies and divides hold busy for a fixed latency and then commit HI/LO together.
module mdu #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] inA,
    input  logic [31:0] inB,
    output logic        busy,
    output logic        done,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [31:0]        a_p0;
    logic [31:0]        b_p0;
    logic               sgn_p0;
    logic               divzero_p0;
    logic [63:0]        mul_res;
    logic [63:0]        div_res;

    // 64-bit product; operands are extended according to signedness first.
    function automatic logic [63:0] mul64(input logic [31:0] a, input logic [31:0] b,
                                          input logic sgn);
        logic signed [63:0] ea;
        logic signed [63:0] eb;
        ea = sgn ? signed'({{32{a[31]}}, a}) : signed'({32'b0, a});
        eb = sgn ? signed'({{32{b[31]}}, b}) : signed'({32'b0, b});
        return 64'(ea * eb);
    endfunction

    // Returns {remainder, quotient}. Signed division works on magnitudes, so
    // 0x80000000 / -1 wraps to 0x80000000 with zero remainder.
    function automatic logic [63:0] div64(input logic [31:0] a, input logic [31:0] b,
                                          input logic sgn);
        logic        neg_a;
        logic        neg_b;
        logic [31:0] ma;
        logic [31:0] mb;
        logic [31:0] q;
        logic [31:0] r;
        neg_a = sgn & a[31];
        neg_b = sgn & b[31];
        ma    = neg_a ? -a : a;
        mb    = neg_b ? -b : b;
        if (mb == 32'd0) begin
            q = 32'd0;
            r = 32'd0;
        end else begin
            q = ma / mb;
            r = ma % mb;
        end
        q = (neg_a ^ neg_b) ? -q : q;
        r = neg_a ? -r : r;
        return {r, q};
    endfunction

    assign mul_res = mul64(a_p0, b_p0, sgn_p0);
    assign div_res = div64(a_p0, b_p0, sgn_p0);

    // Operand capture at acceptance; in-flight operations ignore later input changes.
    always_ff @(posedge clk) begin
        if (start && state == IDLE) begin
            a_p0       <= inA;
            b_p0       <= inB;
            sgn_p0     <= ~op[0];
            divzero_p0 <= (inB == 32'd0);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            HI    <= 32'd0;
            LO    <= 32'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        case (op)
                            OP_MULT, OP_MULTU: begin
                                state <= MUL;
                                busy  <= 1'b1;
                                cnt   <= CNT_W'(MULT_LAT);
                            end
                            OP_DIV, OP_DIVU: begin
                                state <= DIV;
                                busy  <= 1'b1;
                                cnt   <= CNT_W'(DIV_LAT);
                            end
                            OP_MTHI: HI <= inA;
                            OP_MTLO: LO <= inA;
                            default: ;
                        endcase
                    end
                end
                MUL, DIV: begin
                    if (cnt == CNT_W'(1)) begin
                        if (state == MUL) begin
                            HI <= mul_res[63:32];
                            LO <= mul_res[31:0];
                        end else if (!divzero_p0) begin
                            HI <= div_res[63:32];
                            LO <= div_res[31:0];
                        end
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
